// File: rtl/gfx_compositor.sv
// gfx_compositor: raster timing, priority compositing of up to four layer indices through a
// 256-entry palette, frame-shadowed layer registers, and vblank/line-compare interrupts.
module gfx_compositor #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 9,
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_BITS   = 12,
    parameter int H_PIXELS     = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_LINES      = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDRESS_BITS-1:0] i_address,
    input  logic [BITS-1:0]         i_data_in,
    input  logic                    i_wr,
    output logic [BITS-1:0]         o_data_out,
    input  logic [8*NUM_LAYERS-1:0] i_layer_index,
    output logic [9:0]              o_x,
    output logic [9:0]              o_y,
    output logic                    o_h_tick,
    output logic                    o_v_tick,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic [3:0]              o_rr,
    output logic [3:0]              o_gg,
    output logic [3:0]              o_bb,
    output logic                    o_irq
);
    localparam logic [9:0] H_LAST = 10'(H_PIXELS + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST = 10'(V_LINES + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_ACT  = 10'(H_PIXELS);
    localparam logic [9:0] V_ACT  = 10'(V_LINES);
    localparam logic [9:0] HS_ON  = 10'(H_PIXELS + H_FRONT);
    localparam logic [9:0] HS_OFF = 10'(H_PIXELS + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_LINES + V_FRONT);
    localparam logic [9:0] VS_OFF = 10'(V_LINES + V_FRONT + V_SYNC);
    localparam logic [ADDRESS_BITS-1:0] A_CTRL  = ADDRESS_BITS'('h100);
    localparam logic [ADDRESS_BITS-1:0] A_EN    = ADDRESS_BITS'('h101);
    localparam logic [ADDRESS_BITS-1:0] A_PRIO  = ADDRESS_BITS'('h102);
    localparam logic [ADDRESS_BITS-1:0] A_BG    = ADDRESS_BITS'('h103);
    localparam logic [ADDRESS_BITS-1:0] A_FRAME = ADDRESS_BITS'('h104);
    localparam logic [ADDRESS_BITS-1:0] A_ST    = ADDRESS_BITS'('h105);
    localparam logic [ADDRESS_BITS-1:0] A_LINE  = ADDRESS_BITS'('h106);

    logic [9:0]            r_h, r_v;
    logic [3:0]            r_ctrl;
    logic [NUM_LAYERS-1:0] r_en_pend, r_en_act;
    logic [7:0]            r_prio_pend, r_prio_act;
    logic [COLOR_BITS-1:0] r_bg_pend, r_bg_act;
    logic [15:0]           r_frame;
    logic [1:0]            r_st;
    logic [9:0]            r_line;
    logic [BITS-1:0]       r_dout;
    logic [COLOR_BITS-1:0] r_pal [256];
    logic [7:0]            r1_idx;
    logic                  r1_tr, r1_vis, r2_tr, r2_vis;
    logic [COLOR_BITS-1:0] r1_bg, r2_bg, r2_pal, r3_rgb;
    logic [2:0]            r_hs, r_vs;

    logic            w_h_tick, w_v_tick, w_hs, w_vs, w_win;
    logic [1:0]      w_set, w_clr, w_id;
    logic [7:0]      w_idx;
    logic [31:0]     w_lay;
    logic [3:0]      w_en;
    logic [BITS-1:0] w_rd;
    logic            w_unused;

    assign w_h_tick = r_h == 10'd0;
    assign w_v_tick = w_h_tick && r_v == 10'd0;
    assign w_hs     = !(r_h >= HS_ON && r_h < HS_OFF) ^ r_ctrl[1];
    assign w_vs     = !(r_v >= VS_ON && r_v < VS_OFF) ^ r_ctrl[1];
    assign w_set    = {r_h == H_ACT && r_v == r_line, w_h_tick && r_v == V_ACT};
    assign w_clr    = (i_wr && i_address == A_ST) ? i_data_in[1:0] : 2'b00;
    // Missing layers read as index 0 and disabled, so any id >= NUM_LAYERS can never win.
    assign w_lay    = 32'(i_layer_index);
    assign w_en     = 4'(r_en_act);
    assign w_unused = ^i_data_in[BITS-1:COLOR_BITS];

    // Scan from the lowest rank last so rank 0 has the final say.
    always_comb begin
        w_win = 1'b0;
        w_idx = 8'd0;
        w_id  = 2'd0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            w_id = r_prio_act[2*k +: 2];
            if (w_en[w_id] && w_lay[{w_id, 3'b000} +: 4] != 4'd0) begin
                w_win = 1'b1;
                w_idx = w_lay[{w_id, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (i_address)
            A_CTRL:  w_rd = BITS'(r_ctrl);
            A_EN:    w_rd = BITS'(r_en_pend);
            A_PRIO:  w_rd = BITS'(r_prio_pend);
            A_BG:    w_rd = BITS'(r_bg_pend);
            A_FRAME: w_rd = BITS'(r_frame);
            A_ST:    w_rd = BITS'(r_st);
            A_LINE:  w_rd = BITS'(r_line);
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h         <= '0;
            r_v         <= '0;
            r_ctrl      <= '0;
            r_en_pend   <= '1;
            r_en_act    <= '1;
            r_prio_pend <= 8'hE4;
            r_prio_act  <= 8'hE4;
            r_bg_pend   <= '0;
            r_bg_act    <= '0;
            r_frame     <= '0;
            r_st        <= '0;
            r_line      <= '0;
            r_dout      <= '0;
            r1_idx      <= '0;
            r1_tr       <= 1'b0;
            r1_vis      <= 1'b0;
            r1_bg       <= '0;
            r2_tr       <= 1'b0;
            r2_vis      <= 1'b0;
            r2_bg       <= '0;
            r2_pal      <= '0;
            r3_rgb      <= '0;
            r_hs        <= 3'b111;
            r_vs        <= 3'b111;
        end else begin
            r_h <= (r_h == H_LAST) ? '0 : r_h + 10'd1;
            if (r_h == H_LAST) r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
            if (w_v_tick) begin
                r_en_act   <= r_en_pend;
                r_prio_act <= r_prio_pend;
                r_bg_act   <= r_bg_pend;
                r_frame    <= r_frame + 16'd1;
            end
            if (i_wr)
                case (i_address)
                    A_CTRL:  r_ctrl      <= i_data_in[3:0];
                    A_EN:    r_en_pend   <= i_data_in[NUM_LAYERS-1:0];
                    A_PRIO:  r_prio_pend <= i_data_in[7:0];
                    A_BG:    r_bg_pend   <= i_data_in[COLOR_BITS-1:0];
                    A_LINE:  r_line      <= i_data_in[9:0];
                    default: ;
                endcase
            r_st   <= (r_st & ~w_clr) | w_set;
            r_dout <= w_rd;
            r1_idx <= w_idx;
            r1_tr  <= !w_win;
            r1_vis <= r_h < H_ACT && r_v < V_ACT && r_ctrl[0];
            r1_bg  <= r_bg_act;
            r2_tr  <= r1_tr;
            r2_vis <= r1_vis;
            r2_bg  <= r1_bg;
            r2_pal <= r_pal[r1_idx];
            r3_rgb <= r2_vis ? (r2_tr ? r2_bg : r2_pal) : '0;
            r_hs   <= {r_hs[1:0], w_hs};
            r_vs   <= {r_vs[1:0], w_vs};
        end
    end

    always_ff @(posedge i_clk)
        if (i_wr && i_address < A_CTRL) r_pal[i_address[7:0]] <= i_data_in[COLOR_BITS-1:0];

    assign o_x                = r_h;
    assign o_y                = r_v;
    assign o_h_tick           = w_h_tick;
    assign o_v_tick           = w_v_tick;
    assign o_hs               = r_hs[2];
    assign o_vs               = r_vs[2];
    assign {o_rr, o_gg, o_bb} = r3_rgb;
    assign o_data_out         = r_dout;
    assign o_irq              = (r_st[0] & r_ctrl[2]) | (r_st[1] & r_ctrl[3]);
endmodule

// File: doc/gfx_compositor.md
# gfx_compositor

Parametrised video back-end for the gfx subsystem: generates VGA-class timing from parameters, and composites up to four layer colour indices by a programmable priority order. Transparency is per index. The result goes through an internal 256-entry palette with a frame-boundary-shadowed register set, and the block raises vblank and line-compare interrupts. Layer controllers (sprite, background) connect to its X/Y outputs and return one index each per pixel; the CPU and copper write it through a register window.

## Interface
- BITS, 16: data bus width
- ADDRESS_BITS, 9: register window address width
- NUM_LAYERS, 4: layer inputs, 1..4
- COLOR_BITS, 12: palette entry width, RGB 4:4:4
- H_PIXELS, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing in clocks
- V_LINES, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing in lines
- CLK  in  1  pixel clock
- RST  in  1  reset, asynchronous, active-high
- ADDRESS  in  ADDRESS_BITS  register/palette address
- DATA_IN  in  BITS  write data
- WR  in  1  write strobe, one write per cycle
- DATA_OUT  out  BITS  read data, registered
- LAYER_INDEX  in  8*NUM_LAYERS  layer n index in bits [8n+7:8n], valid for the X/Y driven in the same cycle
- X, Y  out  10 each  current raster counters (hcount, vcount)
- H_TICK, V_TICK  out  1  hcount==0 / (hcount==0 && vcount==0)
- HS, VS, RR, GG, BB  out  1,1,4,4,4  video outputs
- IRQ  out  1  level interrupt

## Operation
- Counters: hcount runs 0..H_TOTAL-1, with H_TOTAL = H_PIXELS+H_FRONT+H_SYNC+H_BACK. vcount advances when hcount wraps and runs 0..V_TOTAL-1.
- Active area: hcount<H_PIXELS && vcount<V_LINES.
- Sync pulses:
  - HS is asserted when hcount is in [H_PIXELS+H_FRONT, H_PIXELS+H_FRONT+H_SYNC).
  - VS is asserted over the same window on vcount.
  - Asserted level is 0; CTRL[1]=1 inverts both.
- Register map (pending copy shown on read):
  - 0x000-0x0FF palette: write-only, reads 0.
  - 0x100 CTRL: [0] display enable, [1] sync invert, [2] vblank IRQ enable, [3] line IRQ enable.
  - 0x101 LAYER_EN[NUM_LAYERS-1:0].
  - 0x102 PRIORITY: 2-bit field k = layer id at rank k; rank 0 is topmost.
  - 0x103 BG_COLOR[11:0].
  - 0x104 FRAME_COUNT: read-only, 16-bit.
  - 0x105 IRQ_STATUS: [0] vblank, [1] line; write 1 to clear.
  - 0x106 LINE_CMP[9:0].
  - Unmapped addresses: writes ignored, reads 0.
- Shadowing: LAYER_EN, PRIORITY and BG_COLOR are written into pending copies. Pending copies are copied to active copies on the cycle where V_TICK=1. A write in that same cycle lands in the pending copy and takes effect at the next frame. CTRL, LINE_CMP and palette writes take effect immediately.
- Composite:
  - Scan ranks 0..NUM_LAYERS-1.
  - The first rank whose layer id is < NUM_LAYERS, is enabled in active LAYER_EN, and has index[3:0]!=0 wins.
  - If no rank wins, the pixel is transparent and uses active BG_COLOR. Otherwise the output is palette[index].
  - Duplicate ids are legal; an id missing from PRIORITY is never shown.
- Blanking: RGB is 0 outside the active area or when CTRL[0]=0. Sync generation always runs.
- FRAME_COUNT increments (wrapping) on each V_TICK.
- Interrupt pending bits:
  - Vblank pending is set at hcount==0, vcount==V_LINES.
  - Line pending is set at hcount==H_PIXELS, vcount==LINE_CMP.
  - If a set and a W1C land in the same cycle, set wins.
- IRQ = (st[0]&CTRL[2]) | (st[1]&CTRL[3]).

## Timing
- Pixel pipeline is 3 stages: S1 registers priority winner and transparent flag; S2 palette read; S3 registers RGB.
- HS, VS and the active flag are delayed 3 cycles to match. RGB for X=n appears 3 clocks after X=n is driven.
- X, Y, H_TICK and V_TICK are combinational from the counters, undelayed.
- DATA_OUT is valid 1 cycle after ADDRESS is presented.
- Register writes take effect the cycle after WR, subject to shadowing.
- A palette write to an entry read in the same cycle returns the old value.
- Reset values (any cycle, asynchronous):
  - Counters 0, pipeline cleared.
  - HS=VS=1, RGB=0, DATA_OUT=0, IRQ=0.
  - CTRL=0, LAYER_EN all ones, PRIORITY=0xE4 (rank k = layer k), BG_COLOR=0, FRAME_COUNT=0, IRQ_STATUS=0, LINE_CMP=0.
  - Palette contents are undefined.
- Reset released mid-frame restarts at hcount=vcount=0.

## Test plan
- Timing: reset, run 2 frames at default parameters → HS low 96 clocks every 800, VS low 2 lines every 525, FRAME_COUNT=2, V_TICK period 420000 clocks.
- Priority: palette[0x11]=0xF00, palette[0x22]=0x0F0, CTRL=1. Layer0=0x11, layer1=0x22 → RGB F,0,0 three clocks after X. Then write PRIORITY=0xE1 → RGB unchanged until next V_TICK, then 0,F,0.
- Transparency: all layers index 0x10, BG_COLOR=0x00F → RGB 0,0,F. Same with LAYER_EN=0 and nonzero indices → 0,0,F after the next V_TICK.
- Blanking: CTRL=0 → RGB 0 throughout while HS/VS still toggle. CTRL=3 → HS and VS high-active.
- Interrupts:
  - CTRL=0xD, LINE_CMP=100 → IRQ rises at vcount=100, hcount=640.
  - W1C 0x105=2 on the same cycle as a set → bit remains 1.
  - Vblank sets bit0 at vcount=480.
- Reset mid-line: assert RST at hcount=300 → all outputs at reset values immediately. After release, X=0, Y=0, V_TICK=1 on the first cycle.
